y_signature_compactor: RTL and testbench
========================================

# y_signature_compactor

Downstream consumer of the fuzz design-under-test output bus `y`. It accepts `y` samples over a valid/ready handshake and folds each sample, one 32-bit word per cycle, into a multiple-input signature register (MISR). After a programmed number of samples it compares the signature against a golden value. Simulator and synthesis runs can then be cross-checked with one word instead of a full `$strobe` trace.

## Interface
Parameters:
- `Y_WIDTH`, 82: width of the `y` sample.
- `SIG_WIDTH`, 32: MISR and fold-word width.
- `POLY`, 32'h04C11DB7: Galois feedback polynomial.
- `NUM_SAMPLES`, 21: samples per run; legal range 1..65535.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: one-cycle pulse that starts a run.
- `y_valid` input 1: sample present.
- `y` input `Y_WIDTH`: sample data.
- `y_ready` output 1: block can accept a sample.
- `golden` input `SIG_WIDTH`: expected final signature; sampled in DONE.
- `sig` output `SIG_WIDTH`: current MISR value.
- `sample_cnt` output 16: samples fully folded this run.
- `busy` output 1: high in RUN and FOLD.
- `done` output 1: high in DONE.
- `match` output 1: `done && (sig == golden)`.
- `x_seen` output 1: sticky unknown-input flag (see Configuration).

## Operation
- NWORDS = ceil(Y_WIDTH/SIG_WIDTH). With the defaults this is 3.
- Word k = `y_buf[k*SIG_WIDTH +: SIG_WIDTH]`. The last word is zero-padded above bit `Y_WIDTH-1`. Word 0 is folded first.
- MISR step: `sig <= {sig[SIG_WIDTH-2:0],1'b0} ^ (sig[SIG_WIDTH-1] ? POLY : 0) ^ word`.
- States:
  - IDLE → RUN on `start`. Entering RUN sets `sig` to all-ones, clears `sample_cnt` and clears `x_seen`.
  - RUN: `y_ready=1`. When `y_valid && y_ready`, capture `y` into `y_buf`, clear the word index, go to FOLD.
  - FOLD: one MISR step per cycle, word index 0..NWORDS-1. On the last word, `sample_cnt` increments. If the new count equals NUM_SAMPLES go to DONE, otherwise return to RUN.
  - DONE: hold `sig`; `done=1`. `start` returns to RUN and restarts the run as above.
- `start` in RUN or FOLD is ignored; an in-progress run cannot be aborted except by reset.
- `y_valid` outside RUN is ignored and nothing is captured. `y` need not be held after the capture edge.
- `sample_cnt` saturates at NUM_SAMPLES and never wraps.

## Timing
- Reset values: state IDLE, `sig`=all-ones, `sample_cnt`=0, `y_ready`=0, `busy`=0, `done`=0, `match`=0, `x_seen`=0, `y_buf`=0.
- Reset is asynchronous. Asserting it mid-FOLD discards the partial sample immediately.
- All outputs are registered or decoded from state. No combinational path from `y_valid` to `y_ready`.
- `start` at edge t: `y_ready` is high from cycle t+1.
- Sample accepted at edge t: fold steps occur at edges t+1..t+NWORDS. `y_ready` is high again after edge t+NWORDS, so the next capture is possible at edge t+NWORDS+1. Throughput is one sample per NWORDS+1 cycles.
- Final fold at edge t: `done` and `match` are valid after edge t.
- `golden` may change at any time. `match` follows it combinationally in DONE.

## Configuration
- `SIG_XCHECK_EN` defined (simulation only):
  - On capture, if `^y === 1'bx`, set `x_seen`. It stays set until the next run start or reset.
  - X/Z bits are folded as 0, so `sig` never goes unknown.
- `SIG_XCHECK_EN` undefined: `x_seen` is tied 0 and `y` is captured unmodified.

## Structure
- Shared package `sig_pkg`:
  - State enum IDLE/RUN/FOLD/DONE.
  - Default `POLY` and the seed constant.
  - `NWORDS` computation function.
- One sub-module, `misr_step`: combinational next-signature from `sig`, `word` and `POLY`. The top holds the FSM, the counters, `y_buf` and the handshake.

## Test plan
- Reset mid-FOLD, then release → all outputs at reset values; next `start` runs cleanly from the seed.
- NUM_SAMPLES=1, `start`, then `y`=82'h0 → after 3 fold edges `sig`=32'hE1B8AFFD, `done`=1; `golden`=32'hE1B8AFFD gives `match`=1.
- NUM_SAMPLES=1, `y`=82'h1 → `sig`=32'hE1B8AFF9; `golden`=32'hE1B8AFFD gives `match`=0. Linearity check: XOR of the two results is 32'h4.
- `y_valid` held high continuously with NUM_SAMPLES=21 → exactly one capture every 4 cycles, `sample_cnt` ends at 21, `done` after 84 cycles.
- `start` pulsed during FOLD, and `y_valid` pulsed in IDLE and DONE → ignored; `sig` and `sample_cnt` unchanged.
- With `SIG_XCHECK_EN`, `y` bit 40 = X → `x_seen`=1, `sig` equals the value for that bit = 0; `x_seen` clears on the next `start`.

Source files
------------

// File: rtl/sig_pkg.sv
// Shared types and constants for the y signature compactor.
package sig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [31:0] SIG_POLY_DEFAULT = 32'h04C1_1DB7;
  // Every MISR bit is seeded to this value at the start of a run.
  localparam logic        SIG_SEED_BIT     = 1'b1;

  function automatic int unsigned nwords(input int unsigned y_w, input int unsigned s_w);
    return (y_w + s_w - 1) / s_w;
  endfunction

endpackage

// File: rtl/misr_step.sv
// One Galois MISR step: shift, conditional polynomial feedback, fold in one word.
module misr_step
  import sig_pkg::*;
#(
  parameter int unsigned          SIG_WIDTH = 32,
  parameter logic [SIG_WIDTH-1:0] POLY      = SIG_WIDTH'(SIG_POLY_DEFAULT)
) (
  input  logic [SIG_WIDTH-1:0] sig,
  input  logic [SIG_WIDTH-1:0] word,
  output logic [SIG_WIDTH-1:0] sig_next_c
);

  always_comb begin
    sig_next_c = {sig[SIG_WIDTH-2:0], 1'b0} ^ (sig[SIG_WIDTH-1] ? POLY : '0) ^ word;
  end

endmodule

// File: rtl/y_signature_compactor.sv
// Folds y samples into a MISR and compares the final signature with golden.
// Optional SIG_XCHECK_EN (simulation only): flags X/Z on captured y and folds them as 0.
module y_signature_compactor
  import sig_pkg::*;
#(
  parameter int unsigned          Y_WIDTH     = 82,
  parameter int unsigned          SIG_WIDTH   = 32,
  parameter logic [SIG_WIDTH-1:0] POLY        = SIG_WIDTH'(SIG_POLY_DEFAULT),
  parameter int unsigned          NUM_SAMPLES = 21
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 y_valid,
  input  logic [Y_WIDTH-1:0]   y,
  output logic                 y_ready,
  input  logic [SIG_WIDTH-1:0] golden,
  output logic [SIG_WIDTH-1:0] sig,
  output logic [15:0]          sample_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 match,
  output logic                 x_seen
);

  localparam int unsigned NWORDS = nwords(Y_WIDTH, SIG_WIDTH);
  localparam int unsigned PAD_W  = NWORDS * SIG_WIDTH;
  localparam int unsigned WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned CNT_W  = 16;

  localparam logic [WIDX_W-1:0]    WIDX_LAST  = WIDX_W'(NWORDS - 1);
  localparam logic [CNT_W-1:0]     CNT_TARGET = CNT_W'(NUM_SAMPLES);
  localparam logic [SIG_WIDTH-1:0] SIG_SEED   = {SIG_WIDTH{SIG_SEED_BIT}};

  state_t               state_q, state_d;
  logic [SIG_WIDTH-1:0] sig_q, sig_d, sig_step, fold_word;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [Y_WIDTH-1:0]   y_buf_q, y_buf_d, y_cap;
  logic [WIDX_W-1:0]    widx_q, widx_d;
  logic [PAD_W-1:0]     y_pad;
  logic                 run_start, capture;

  assign run_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign capture   = y_valid && (state_q == ST_RUN);

`ifdef SIG_XCHECK_EN
  logic y_has_x;
  logic x_seen_q;

  // Unknown bits are recorded, then scrubbed to 0 so the signature stays known.
  always_comb begin
    y_has_x = (^y === 1'bx);
    for (int unsigned i = 0; i < Y_WIDTH; i++) begin
      y_cap[i] = (y[i] === 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_seen_q <= 1'b0;
    end else if (run_start) begin
      x_seen_q <= 1'b0;
    end else if (capture && y_has_x) begin
      x_seen_q <= 1'b1;
    end
  end

  assign x_seen = x_seen_q;
`else
  assign y_cap  = y;
  assign x_seen = 1'b0;
`endif

  // Zero-pad the sample to whole words and select the word being folded.
  always_comb begin
    y_pad     = PAD_W'(y_buf_q);
    fold_word = '0;
    for (int unsigned k = 0; k < NWORDS; k++) begin
      if (widx_q == WIDX_W'(k)) begin
        fold_word = y_pad[k*SIG_WIDTH +: SIG_WIDTH];
      end
    end
  end

  misr_step #(
    .SIG_WIDTH (SIG_WIDTH),
    .POLY      (POLY)
  ) u_misr_step (
    .sig        (sig_q),
    .word       (fold_word),
    .sig_next_c (sig_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sig_q   <= SIG_SEED;
      cnt_q   <= '0;
      y_buf_q <= '0;
      widx_q  <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      y_buf_q <= y_buf_d;
      widx_q  <= widx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    y_buf_d = y_buf_q;
    widx_d  = widx_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (run_start) begin
          state_d = ST_RUN;
          sig_d   = SIG_SEED;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (capture) begin
          y_buf_d = y_cap;
          widx_d  = '0;
          state_d = ST_FOLD;
        end
      end
      ST_FOLD: begin
        sig_d  = sig_step;
        widx_d = widx_q + 1'b1;
        if (widx_q == WIDX_LAST) begin
          // Count saturates at the run length.
          if (cnt_q != CNT_TARGET) begin
            cnt_d = cnt_q + 1'b1;
          end
          state_d = (cnt_d == CNT_TARGET) ? ST_DONE : ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign y_ready    = (state_q == ST_RUN);
  assign busy       = (state_q == ST_RUN) || (state_q == ST_FOLD);
  assign done       = (state_q == ST_DONE);
  assign match      = (state_q == ST_DONE) && (sig_q == golden);
  assign sig        = sig_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_y_signature_compactor.sv
// Directed bench: single-sample signature table plus multi-cycle corner sequences.
module tb_y_signature_compactor;

  localparam int unsigned YW = 82;
  localparam int unsigned SW = 32;
  localparam logic [SW-1:0] SIG_ZERO = 32'hE1B8_AFFD;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance a: one sample per run
  logic          a_start, a_valid, a_ready, a_busy, a_done, a_match, a_x;
  logic [YW-1:0] a_y;
  logic [SW-1:0] a_golden, a_sig;
  logic [15:0]   a_cnt;

  // Instance b: default 21 samples per run
  logic          b_start, b_valid, b_ready, b_busy, b_done, b_match, b_x;
  logic [YW-1:0] b_y;
  logic [SW-1:0] b_golden, b_sig;
  logic [15:0]   b_cnt;

  y_signature_compactor #(.NUM_SAMPLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .y_valid(a_valid), .y(a_y),
    .y_ready(a_ready), .golden(a_golden), .sig(a_sig), .sample_cnt(a_cnt),
    .busy(a_busy), .done(a_done), .match(a_match), .x_seen(a_x)
  );

  y_signature_compactor dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .y_valid(b_valid), .y(b_y),
    .y_ready(b_ready), .golden(b_golden), .sig(b_sig), .sample_cnt(b_cnt),
    .busy(b_busy), .done(b_done), .match(b_match), .x_seen(b_x)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference for the multi-sample run.
  function automatic logic [SW-1:0] fold(input logic [SW-1:0] s, input logic [YW-1:0] v);
    logic [3*SW-1:0] p;
    logic [SW-1:0]   w;
    p = {14'b0, v};
    for (int k = 0; k < 3; k++) begin
      w = p[k*SW +: SW];
      s = {s[SW-2:0], 1'b0} ^ (s[SW-1] ? 32'h04C1_1DB7 : 32'h0) ^ w;
    end
    return s;
  endfunction

  function automatic logic [YW-1:0] samp(input int k);
    return {18'(k + 7), 32'(k * 3 + 1), 32'hA5A5_0000 | 32'(k)};
  endfunction

  // One full single-sample run on instance a.
  task automatic run_a(input logic [YW-1:0] v, output logic [SW-1:0] s);
    a_start = 1'b1; tick(); a_start = 1'b0;
    check("a_ready_after_start", a_ready, 1'b1);
    a_valid = 1'b1; a_y = v; tick();
    a_valid = 1'b0; a_y = ~v;
    tick(); tick(); tick();
    s = a_sig;
  endtask

  typedef struct {
    logic [YW-1:0] y;
    logic [SW-1:0] sig;
    logic          match;
  } vec_t;

  vec_t vecs[8];

  logic [SW-1:0] s0, s1, s_tmp, exp_sig;
  logic [YW-1:0] cur_y;
  int            cyc, k, last_cap, gaps_bad;
  logic          cap;

  initial begin
    vecs[0] = '{82'h0,                           32'hE1B8_AFFD, 1'b1};
    vecs[1] = '{82'h1,                           32'hE1B8_AFF9, 1'b0};
    vecs[2] = '{82'h8000_0000,                   32'hE83A_9493, 1'b0};
    vecs[3] = '{82'h1_0000_0000,                 32'hE1B8_AFFF, 1'b0};
    vecs[4] = '{82'h8000_0000_0000_0000,         32'hE579_B24A, 1'b0};
    vecs[5] = '{82'h1_0000_0000_0000_0000,       32'hE1B8_AFFC, 1'b0};
    vecs[6] = '{82'h2_0000_0000_0000_0000_0000,  32'hE1BA_AFFD, 1'b0};
    vecs[7] = '{82'h1_0000_0000_0000_0002,       32'hE1B8_AFF4, 1'b0};

    rst_n = 1'b0;
    a_start = 0; a_valid = 0; a_y = '0; a_golden = SIG_ZERO;
    b_start = 0; b_valid = 0; b_y = '0; b_golden = '0;
    #12 rst_n = 1'b1;
    tick();

    check("rst_sig",   a_sig,   32'hFFFF_FFFF);
    check("rst_cnt",   a_cnt,   16'd0);
    check("rst_ready", a_ready, 1'b0);
    check("rst_busy",  a_busy,  1'b0);
    check("rst_done",  a_done,  1'b0);
    check("rst_match", a_match, 1'b0);
    check("rst_xseen", a_x,     1'b0);

    // y_valid in IDLE is ignored
    a_valid = 1'b1; a_y = 82'h1; tick(); tick(); a_valid = 1'b0;
    check("idle_valid_busy", a_busy, 1'b0);
    check("idle_valid_sig",  a_sig,  32'hFFFF_FFFF);

    // Reset asserted mid-FOLD discards the partial sample immediately
    a_start = 1'b1; tick(); a_start = 1'b0;
    a_valid = 1'b1; a_y = 82'h1; tick(); a_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midfold_rst_sig",   a_sig,   32'hFFFF_FFFF);
    check("midfold_rst_busy",  a_busy,  1'b0);
    check("midfold_rst_ready", a_ready, 1'b0);
    check("midfold_rst_cnt",   a_cnt,   16'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    run_a(82'h0, s_tmp);
    check("post_rst_run_sig", s_tmp, SIG_ZERO);

    // Table of single-sample signatures
    for (int i = 0; i < 8; i++) begin
      run_a(vecs[i].y, s_tmp);
      check($sformatf("vec%0d_sig", i),   s_tmp,   vecs[i].sig);
      check($sformatf("vec%0d_done", i),  a_done,  1'b1);
      check($sformatf("vec%0d_match", i), a_match, vecs[i].match);
      check($sformatf("vec%0d_cnt", i),   a_cnt,   16'd1);
      if (i == 0) s0 = s_tmp;
      if (i == 1) s1 = s_tmp;
    end
    check("linearity", s0 ^ s1, 32'h4);

    // golden changes are reflected in match while in DONE
    a_golden = vecs[7].sig; #1;
    check("golden_follow_match", a_match, 1'b1);
    a_golden = SIG_ZERO; #1;
    check("golden_follow_nomatch", a_match, 1'b0);

    // y_valid in DONE is ignored
    a_valid = 1'b1; a_y = 82'h1; tick(); tick(); a_valid = 1'b0;
    check("done_valid_sig",  a_sig,  vecs[7].sig);
    check("done_valid_cnt",  a_cnt,  16'd1);
    check("done_valid_done", a_done, 1'b1);

    // start during FOLD is ignored
    a_start = 1'b1; tick(); a_start = 1'b0;
    a_valid = 1'b1; a_y = 82'h0; tick(); a_valid = 1'b0;
    a_start = 1'b1; tick(); a_start = 1'b0;
    check("fold_start_busy", a_busy, 1'b1);
    tick(); tick();
    check("fold_start_sig",  a_sig,  SIG_ZERO);
    check("fold_start_done", a_done, 1'b1);
    check("fold_start_cnt",  a_cnt,  16'd1);

    // Instance b: y_valid held high for a full 21-sample run
    b_start = 1'b1; tick(); b_start = 1'b0;
    b_valid = 1'b1; b_y = samp(0);
    exp_sig = 32'hFFFF_FFFF; cyc = 0; k = 0; last_cap = 0; gaps_bad = 0;
    while (!b_done && cyc < 200) begin
      cap   = b_ready;
      cur_y = b_y;
      tick(); cyc++;
      if (cap) begin
        exp_sig = fold(exp_sig, cur_y);
        if (k > 0 && (cyc - last_cap) != 4) gaps_bad++;
        last_cap = cyc;
        k++;
        b_y = samp(k);
      end
    end
    check("b_done_cycles", 64'(cyc), 64'd84);
    check("b_captures",    64'(k),   64'd21);
    check("b_gaps",        64'(gaps_bad), 64'd0);
    check("b_cnt",         b_cnt,    16'd21);
    check("b_sig",         b_sig,    exp_sig);
    b_golden = exp_sig; #1;
    check("b_match",       b_match,  1'b1);
    tick(); tick(); tick(); tick(); tick();
    check("b_cnt_hold",    b_cnt,    16'd21);
    check("b_sig_hold",    b_sig,    exp_sig);
    b_valid = 1'b0;

`ifdef SIG_XCHECK_EN
    // Unknown bit 40 is flagged and folded as 0
    a_y = '0;
    a_start = 1'b1; tick(); a_start = 1'b0;
    a_valid = 1'b1; a_y = '0; a_y[40] = 1'bx; tick();
    a_valid = 1'b0; a_y = '0;
    tick(); tick(); tick();
    check("x_seen_set", a_x,   1'b1);
    check("x_sig",      a_sig, SIG_ZERO);
    a_start = 1'b1; tick(); a_start = 1'b0;
    check("x_seen_clear", a_x, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
